// File: rtl/wb_sram_bridge.sv
// Wishbone slave to asynchronous 8-bit SRAM bridge.
// Multi-cycle SETUP/ACCESS/HOLD strobe sequencing with abort and ack hold.
module wb_sram_bridge #(
   parameter int AW          = 16,
   parameter int WAIT_CYCLES = 1
) (
   input  logic          clk_i,
   input  logic          nrst_i,
   input  logic [AW-1:0] wbs_adr_i,
   input  logic [1:0]    wbs_tga_i,
   input  logic [7:0]    wbs_dat_i,
   output logic [7:0]    wbs_dat_o,
   input  logic          wbs_cyc_i,
   input  logic          wbs_stb_i,
   input  logic          wbs_we_i,
   output logic          wbs_ack_o,
   output logic [AW-1:0] sram_a_o,
   input  logic [7:0]    sram_d_i,
   output logic [7:0]    sram_d_o,
   output logic          sram_d_oe_o,
   output logic          sram_ce_n_o,
   output logic          sram_oe_n_o,
   output logic          sram_we_n_o
);

   if (WAIT_CYCLES < 0 || WAIT_CYCLES > 7) begin : g_bad_wait
      $error("wb_sram_bridge: WAIT_CYCLES must be 0..7");
   end

   localparam logic [2:0] WAIT_LD = 3'(WAIT_CYCLES);

   typedef enum logic [2:0] {
      S_IDLE,
      S_SETUP,
      S_ACCESS,
      S_HOLD,
      S_DONE
   } state_e;

   state_e        state_q, state_d;
   logic [2:0]    cnt_q, cnt_d;
   logic          abort_q, abort_d;
   logic          ack_q;
   logic          we_q;
   logic [AW-1:0] adr_q;
   logic [7:0]    wdat_q;
   logic [7:0]    rdat_q;

   logic req;
   logic accept;
   logic rd_cap;

   assign req    = wbs_cyc_i & wbs_stb_i & (wbs_tga_i == 2'b00);
   assign accept = (state_q == S_IDLE) & req;
   assign rd_cap = (state_q == S_ACCESS) & ~we_q & wbs_stb_i
                 & (cnt_q == 3'd0);

   // State register
   always_ff @(posedge clk_i or negedge nrst_i) begin
      if (!nrst_i) begin
         state_q <= S_IDLE;
         cnt_q   <= 3'd0;
         abort_q <= 1'b0;
         ack_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         abort_q <= abort_d;
         ack_q   <= (state_d == S_DONE);
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      abort_d = abort_q;
      unique case (state_q)
         S_IDLE: begin
            if (req) begin
               state_d = S_SETUP;
               abort_d = 1'b0;
            end
         end
         S_SETUP: begin
            cnt_d = WAIT_LD;
            if (!wbs_stb_i && !we_q) begin
               state_d = S_IDLE;
            end else begin
               state_d = S_ACCESS;
               if (!wbs_stb_i) abort_d = 1'b1;
            end
         end
         S_ACCESS: begin
            if (!wbs_stb_i && !we_q) begin
               state_d = S_IDLE;
            end else begin
               if (!wbs_stb_i) abort_d = 1'b1;
               if (cnt_q == 3'd0) begin
                  state_d = we_q ? S_HOLD : S_DONE;
               end else begin
                  cnt_d = cnt_q - 3'd1;
               end
            end
         end
         // A write dropped by the master still finishes its pulse
         S_HOLD: begin
            if (abort_q || !wbs_stb_i) state_d = S_IDLE;
            else                       state_d = S_DONE;
         end
         S_DONE: begin
            if (!wbs_stb_i) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Output decode
   always_comb begin
      sram_ce_n_o = 1'b1;
      sram_oe_n_o = 1'b1;
      sram_we_n_o = 1'b1;
      sram_d_oe_o = 1'b0;
      unique case (state_q)
         S_SETUP: begin
            sram_ce_n_o = 1'b0;
            sram_oe_n_o = we_q;
            sram_d_oe_o = we_q;
         end
         S_ACCESS: begin
            sram_ce_n_o = 1'b0;
            sram_oe_n_o = we_q;
            sram_we_n_o = ~we_q;
            sram_d_oe_o = we_q;
         end
         S_HOLD: begin
            sram_ce_n_o = 1'b0;
            sram_d_oe_o = 1'b1;
         end
         default: begin
            sram_ce_n_o = 1'b1;
         end
      endcase
   end

   // Request latch and read capture
   always_ff @(posedge clk_i or negedge nrst_i) begin
      if (!nrst_i) begin
         adr_q  <= '0;
         wdat_q <= 8'h00;
         we_q   <= 1'b0;
         rdat_q <= 8'h00;
      end else begin
         if (accept) begin
            adr_q  <= wbs_adr_i;
            wdat_q <= wbs_dat_i;
            we_q   <= wbs_we_i;
         end
         if (rd_cap) rdat_q <= sram_d_i;
      end
   end

   assign wbs_ack_o = ack_q;
   assign wbs_dat_o = rdat_q;
   assign sram_a_o  = adr_q;
   assign sram_d_o  = wdat_q;

endmodule

// File: tb/tb_wb_sram_bridge.sv
// Scoreboard bench for wb_sram_bridge with a behavioural SRAM.
// Acks are checked by a monitor against queued expectations.
module tb_wb_sram_bridge;

   localparam int AW = 16;

   logic          clk = 1'b0;
   logic          nrst = 1'b0;
   logic [AW-1:0] adr = '0;
   logic [1:0]    tga = 2'b00;
   logic [7:0]    wdat = 8'h00;
   logic [7:0]    rdat;
   logic          cyc_i = 1'b0;
   logic          stb = 1'b0;
   logic          we = 1'b0;
   logic          ack;
   logic [AW-1:0] sram_a;
   logic [7:0]    sram_di;
   logic [7:0]    sram_do;
   logic          doe, ce_n, oe_n, we_n;

   wb_sram_bridge #(.AW(AW), .WAIT_CYCLES(1)) dut (
      .clk_i       (clk),
      .nrst_i      (nrst),
      .wbs_adr_i   (adr),
      .wbs_tga_i   (tga),
      .wbs_dat_i   (wdat),
      .wbs_dat_o   (rdat),
      .wbs_cyc_i   (cyc_i),
      .wbs_stb_i   (stb),
      .wbs_we_i    (we),
      .wbs_ack_o   (ack),
      .sram_a_o    (sram_a),
      .sram_d_i    (sram_di),
      .sram_d_o    (sram_do),
      .sram_d_oe_o (doe),
      .sram_ce_n_o (ce_n),
      .sram_oe_n_o (oe_n),
      .sram_we_n_o (we_n)
   );

   always #5 clk = ~clk;

   int cyc;
   always @(posedge clk) cyc <= cyc + 1;

   // Behavioural SRAM
   logic [7:0] mem [0:65535];
   assign sram_di = mem[sram_a];
   initial begin : sram_model
      for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
      mem[16'h1234] = 8'hA5;
      mem[16'h0001] = 8'h77;
      forever begin
         @(negedge clk);
         if (nrst && !ce_n && !we_n && doe) mem[sram_a] = sram_do;
      end
   end

   typedef struct {
      string      name;
      logic [7:0] dat;
      bit         rd;
      int         lat;
      int         req_cyc;
   } exp_t;
   exp_t sb[$];

   int   mon_cmp, mon_err;
   int   oe_cnt, we_cnt, doe_cnt, ce_cnt, bad_cnt;
   logic ack_prev = 1'b0;
   exp_t mon_e;
   int   mon_lat;

   always @(negedge clk) begin
      if (!oe_n) oe_cnt++;
      if (!we_n) we_cnt++;
      if (doe) doe_cnt++;
      if (!ce_n) ce_cnt++;
      if ((!we_n && !oe_n) || (doe && !oe_n)) bad_cnt++;
      if (ack && !ack_prev) begin
         mon_cmp++;
         if (sb.size() == 0) begin
            mon_err++;
            $display("FAIL unexpected_ack: ack=1 at cyc %0d, required no ack",
                     cyc);
         end else begin
            mon_e   = sb.pop_front();
            mon_lat = cyc - mon_e.req_cyc;
            if (mon_lat != mon_e.lat) begin
               mon_err++;
               $display("FAIL %s_latency: got %0d edges, required %0d",
                        mon_e.name, mon_lat, mon_e.lat);
            end
            if (mon_e.rd) begin
               mon_cmp++;
               if (rdat !== mon_e.dat) begin
                  mon_err++;
                  $display("FAIL %s_data: got %02h, required %02h",
                           mon_e.name, rdat, mon_e.dat);
               end
            end
         end
      end
      ack_prev = ack;
   end

   int n_cmp, n_err;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, required %0h", nm, act, exp);
      end
   endtask

   task automatic start(input logic [15:0] a, input logic [1:0] t,
                        input logic w, input logic [7:0] d);
      @(negedge clk);
      adr   = a;
      tga   = t;
      we    = w;
      wdat  = d;
      cyc_i = 1'b1;
      stb   = 1'b1;
   endtask

   task automatic release_bus();
      stb   = 1'b0;
      cyc_i = 1'b0;
   endtask

   task automatic wait_ack(input string nm, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (ack) begin
            ok = 1'b1;
            break;
         end
      end
      chk({nm, "_ack_seen"}, 32'(ok), 32'd1);
   endtask

   task automatic do_read(input string nm, input logic [15:0] a,
                          input logic [7:0] expd, input int hold);
      bit ok;
      int n;
      start(a, 2'b00, 1'b0, 8'h00);
      sb.push_back('{name: nm, dat: expd, rd: 1'b1, lat: 3, req_cyc: cyc + 1});
      wait_ack(nm, ok);
      if (ok && hold > 0) begin
         n = 0;
         repeat (hold) begin
            @(negedge clk);
            if (ack) n++;
         end
         chk({nm, "_ack_hold"}, 32'(n), 32'(hold));
      end
      release_bus();
      @(negedge clk);
      chk({nm, "_ack_low"}, 32'(ack), 32'd0);
      chk({nm, "_ce_idle"}, 32'(ce_n), 32'd1);
   endtask

   task automatic do_write(input string nm, input logic [15:0] a,
                           input logic [7:0] d);
      bit ok;
      start(a, 2'b00, 1'b1, d);
      sb.push_back('{name: nm, dat: 8'h00, rd: 1'b0, lat: 4, req_cyc: cyc + 1});
      wait_ack(nm, ok);
      release_bus();
      @(negedge clk);
      chk({nm, "_ack_low"}, 32'(ack), 32'd0);
   endtask

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin : stim
      int oe0, we0, doe0, ce0, acks;
      repeat (3) @(negedge clk);
      chk("rst_ack", 32'(ack), 32'd0);
      chk("rst_dat", 32'(rdat), 32'h00);
      chk("rst_ce_n", 32'(ce_n), 32'd1);
      chk("rst_oe_n", 32'(oe_n), 32'd1);
      chk("rst_we_n", 32'(we_n), 32'd1);
      chk("rst_doe", 32'(doe), 32'd0);
      chk("rst_addr", 32'(sram_a), 32'h0);
      chk("rst_dout", 32'(sram_do), 32'h0);
      nrst = 1'b1;

      // Read A5 with 5-cycle ack hold
      oe0 = oe_cnt;
      we0 = we_cnt;
      do_read("rd_a5", 16'h1234, 8'hA5, 5);
      chk("rd_a5_oe_cycles", 32'(oe_cnt - oe0), 32'd3);
      chk("rd_a5_we_cycles", 32'(we_cnt - we0), 32'd0);

      // Write 3C
      we0  = we_cnt;
      doe0 = doe_cnt;
      do_write("wr_3c", 16'hC000, 8'h3C);
      chk("wr_3c_we_cycles", 32'(we_cnt - we0), 32'd2);
      chk("wr_3c_doe_cycles", 32'(doe_cnt - doe0), 32'd4);
      chk("wr_3c_mem", 32'(mem[16'hC000]), 32'h3C);
      chk("wr_3c_dat_kept", 32'(rdat), 32'hA5);

      do_read("rd_3c", 16'hC000, 8'h3C, 0);

      // Non-memory tag is ignored
      ce0  = ce_cnt;
      acks = 0;
      start(16'h1234, 2'b01, 1'b0, 8'h00);
      repeat (10) begin
         @(negedge clk);
         if (ack) acks++;
      end
      release_bus();
      @(negedge clk);
      chk("io_tag_acks", 32'(acks), 32'd0);
      chk("io_tag_ce_cycles", 32'(ce_cnt - ce0), 32'd0);

      // Read abort in ACCESS
      start(16'h0001, 2'b00, 1'b0, 8'h00);
      @(negedge clk);
      @(negedge clk);
      release_bus();
      @(negedge clk);
      chk("rd_abort_oe_n", 32'(oe_n), 32'd1);
      chk("rd_abort_ce_n", 32'(ce_n), 32'd1);
      repeat (5) @(negedge clk);
      chk("rd_abort_dat_kept", 32'(rdat), 32'h3C);

      // Write abort in ACCESS
      we0  = we_cnt;
      doe0 = doe_cnt;
      start(16'h0002, 2'b00, 1'b1, 8'h5A);
      @(negedge clk);
      @(negedge clk);
      release_bus();
      repeat (6) @(negedge clk);
      chk("wr_abort_we_cycles", 32'(we_cnt - we0), 32'd2);
      chk("wr_abort_doe_cycles", 32'(doe_cnt - doe0), 32'd4);
      chk("wr_abort_mem", 32'(mem[16'h0002]), 32'h5A);
      chk("wr_abort_ce_n", 32'(ce_n), 32'd1);

      do_read("rd_5a", 16'h0002, 8'h5A, 0);

      // Reset during write ACCESS
      start(16'h0010, 2'b00, 1'b1, 8'h99);
      @(negedge clk);
      @(negedge clk);
      chk("mid_wr_we_low", 32'(we_n), 32'd0);
      #2 nrst = 1'b0;
      #1;
      chk("arst_we_n", 32'(we_n), 32'd1);
      chk("arst_ce_n", 32'(ce_n), 32'd1);
      chk("arst_oe_n", 32'(oe_n), 32'd1);
      chk("arst_doe", 32'(doe), 32'd0);
      chk("arst_ack", 32'(ack), 32'd0);
      chk("arst_addr", 32'(sram_a), 32'h0);
      chk("arst_dout", 32'(sram_do), 32'h0);
      chk("arst_dat", 32'(rdat), 32'h00);
      release_bus();
      @(negedge clk);
      nrst = 1'b1;
      repeat (4) @(negedge clk);
      chk("post_rst_ce_n", 32'(ce_n), 32'd1);

      do_read("rd_after_rst", 16'h1234, 8'hA5, 0);

      repeat (3) @(negedge clk);
      chk("sb_drained", 32'(sb.size()), 32'd0);
      chk("strobe_overlap", 32'(bad_cnt), 32'd0);

      n_cmp = n_cmp + mon_cmp;
      n_err = n_err + mon_err;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
